// File: rtl/mem_ctrl.sv
// mem_ctrl: data-port FSM serving a byte-enabled 16-bit RAM and an MMIO
// channel array (with wait timeout), plus an independent, non-stalling
// instruction fetch port that reads the same RAM.
module mem_ctrl #(
    parameter int unsigned       ADDR_W       = 16,
    parameter int unsigned       RAM_WORDS    = 2048,
    parameter logic [ADDR_W-1:0] MMIO_BASE    = 16'hF000,
    parameter int unsigned       N_MMIO       = 4,
    parameter int unsigned       MMIO_TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [15:0]         data_wdata,
    input  logic                data_size,
    input  logic                data_write,
    input  logic                data_req,
    output logic [15:0]         data_rdata,
    output logic                data_done,
    output logic                data_err,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic                inst_req,
    output logic [15:0]         inst_out,
    output logic                inst_done,
    output logic                mmio_req,
    output logic [N_MMIO-1:0]   mmio_sel,
    output logic                mmio_write,
    output logic [7:0]          mmio_wdata,
    input  logic [N_MMIO-1:0]   mmio_done,
    input  logic [8*N_MMIO-1:0] mmio_rdata
);

    localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int unsigned TMO_CW = $clog2(MMIO_TIMEOUT + 1);
    localparam int unsigned TMO_W  = (TMO_CW > 8) ? TMO_CW : 8;

    localparam logic [ADDR_W-1:0] RAM_LIMIT  = ADDR_W'(RAM_WORDS);
    localparam logic [ADDR_W-1:0] MMIO_COUNT = ADDR_W'(N_MMIO);
    // Last counter value seen in MMIO_WAIT before giving up on the channel
    localparam logic [TMO_W-1:0]  TMO_LAST   = (MMIO_TIMEOUT > 0) ? TMO_W'(MMIO_TIMEOUT - 1) : '0;
    localparam logic [TMO_W-1:0]  TMO_ONE    = TMO_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAM_RD    = 3'd1,
        RAM_WR    = 3'd2,
        MMIO_WAIT = 3'd3,
        RESP      = 3'd4
    } state_t;

    // Read data formatting: bytes are zero-extended, addr[0]=1 picks the high byte
    function automatic logic [15:0] fmt_rdata(input logic [15:0] wd, input logic size, input logic hi);
        logic [15:0] r;
        if (size) begin
            r = wd;
        end else if (hi) begin
            r = {8'h00, wd[15:8]};
        end else begin
            r = {8'h00, wd[7:0]};
        end
        return r;
    endfunction

    // Storage: not reset, contents survive reset
    logic [15:0] ram_q [RAM_WORDS];

    state_t              state_q, state_d;
    logic [RAM_AW-1:0]   idx_q, idx_d;
    logic                hi_q, hi_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                size_q, size_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [15:0]         data_rdata_q, data_rdata_d;
    logic                data_done_q, data_done_d;
    logic                data_err_q, data_err_d;
    logic                mmio_req_q, mmio_req_d;
    logic [N_MMIO-1:0]   mmio_sel_q, mmio_sel_d;
    logic                mmio_write_q, mmio_write_d;
    logic [7:0]          mmio_wdata_q, mmio_wdata_d;
    logic [15:0]         inst_out_q, inst_out_d;
    logic                inst_done_q, inst_done_d;

    logic [ADDR_W-1:0]   acc_off_s;
    logic                acc_ram_s;
    logic                acc_mmio_s;
    logic                acc_bad_s;
    logic [N_MMIO-1:0]   acc_sel_s;
    logic                sel_done_s;
    logic [7:0]          sel_byte_s;
    logic                ram_we_s;
    logic [1:0]          ram_be_s;
    logic [15:0]         ram_wd_s;
    logic                inst_in_range_s;
    logic                unused_inst_lsb_s;

    assign unused_inst_lsb_s = inst_addr[0];

    // Address decode of the incoming data request (RAM / MMIO channel / unmapped)
    always_comb begin
        acc_off_s  = data_addr - MMIO_BASE;
        acc_ram_s  = (data_addr < MMIO_BASE) && ({1'b0, data_addr[ADDR_W-1:1]} < RAM_LIMIT);
        acc_mmio_s = (data_addr >= MMIO_BASE) && (acc_off_s < MMIO_COUNT);
        acc_bad_s  = (data_size && data_addr[0]) ||
                     (data_size && acc_mmio_s) ||
                     (!acc_ram_s && !acc_mmio_s);
        acc_sel_s  = '0;
        for (int k = 0; k < int'(N_MMIO); k++) begin
            acc_sel_s[k] = acc_mmio_s && (acc_off_s == ADDR_W'(k));
        end
    end

    // Completion and read byte of the selected MMIO channel only
    always_comb begin
        sel_done_s = 1'b0;
        sel_byte_s = 8'h00;
        for (int k = 0; k < int'(N_MMIO); k++) begin
            sel_done_s = sel_done_s | (mmio_sel_q[k] & mmio_done[k]);
            sel_byte_s = sel_byte_s | (mmio_rdata[8*k +: 8] & {8{mmio_sel_q[k]}});
        end
    end

    // Data FSM next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        hi_d         = hi_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        tmo_d        = tmo_q;
        data_rdata_d = 16'h0000;
        data_done_d  = 1'b0;
        data_err_d   = 1'b0;
        mmio_req_d   = mmio_req_q;
        mmio_sel_d   = mmio_sel_q;
        mmio_write_d = mmio_write_q;
        mmio_wdata_d = mmio_wdata_q;
        ram_we_s     = 1'b0;
        ram_be_s     = 2'b00;
        ram_wd_s     = 16'h0000;

        case (state_q)
            IDLE: begin
                if (data_req) begin
                    idx_d   = data_addr[RAM_AW:1];
                    hi_d    = data_addr[0];
                    wdata_d = data_wdata;
                    size_d  = data_size;
                    tmo_d   = '0;
                    if (acc_bad_s) begin
                        // Rejected without touching RAM or MMIO
                        state_d     = RESP;
                        data_done_d = 1'b1;
                        data_err_d  = 1'b1;
                    end else if (acc_mmio_s) begin
                        state_d      = MMIO_WAIT;
                        mmio_req_d   = 1'b1;
                        mmio_sel_d   = acc_sel_s;
                        mmio_write_d = data_write;
                        mmio_wdata_d = data_wdata[7:0];
                    end else if (data_write) begin
                        state_d = RAM_WR;
                    end else begin
                        state_d = RAM_RD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RAM_RD: begin
                state_d      = RESP;
                data_done_d  = 1'b1;
                data_rdata_d = fmt_rdata(ram_q[idx_q], size_q, hi_q);
            end
            RAM_WR: begin
                // Byte enables avoid a read-modify-write of the partner byte
                ram_we_s    = 1'b1;
                ram_be_s    = size_q ? 2'b11 : (hi_q ? 2'b10 : 2'b01);
                ram_wd_s    = size_q ? wdata_q : {wdata_q[7:0], wdata_q[7:0]};
                state_d     = RESP;
                data_done_d = 1'b1;
            end
            MMIO_WAIT: begin
                if (sel_done_s) begin
                    state_d      = RESP;
                    data_done_d  = 1'b1;
                    data_rdata_d = {8'h00, sel_byte_s};
                    mmio_req_d   = 1'b0;
                    mmio_sel_d   = '0;
                    mmio_write_d = 1'b0;
                    mmio_wdata_d = 8'h00;
                end else if (tmo_q >= TMO_LAST) begin
                    state_d      = RESP;
                    data_done_d  = 1'b1;
                    data_err_d   = 1'b1;
                    mmio_req_d   = 1'b0;
                    mmio_sel_d   = '0;
                    mmio_write_d = 1'b0;
                    mmio_wdata_d = 8'h00;
                end else begin
                    tmo_d = (tmo_q == '1) ? tmo_q : (tmo_q + TMO_ONE);
                end
            end
            RESP: begin
                // Completion cycle: a held request is not re-accepted here
                state_d = IDLE;
            end
            default: begin
                state_d      = IDLE;
                mmio_req_d   = 1'b0;
                mmio_sel_d   = '0;
                mmio_write_d = 1'b0;
                mmio_wdata_d = 8'h00;
            end
        endcase
    end

    // Data FSM state and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            hi_q         <= 1'b0;
            wdata_q      <= 16'h0000;
            size_q       <= 1'b0;
            tmo_q        <= '0;
            data_rdata_q <= 16'h0000;
            data_done_q  <= 1'b0;
            data_err_q   <= 1'b0;
            mmio_req_q   <= 1'b0;
            mmio_sel_q   <= '0;
            mmio_write_q <= 1'b0;
            mmio_wdata_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            hi_q         <= hi_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            tmo_q        <= tmo_d;
            data_rdata_q <= data_rdata_d;
            data_done_q  <= data_done_d;
            data_err_q   <= data_err_d;
            mmio_req_q   <= mmio_req_d;
            mmio_sel_q   <= mmio_sel_d;
            mmio_write_q <= mmio_write_d;
            mmio_wdata_q <= mmio_wdata_d;
        end
    end

    // RAM write port: byte-enabled commit leaving RAM_WR, suppressed while reset is low
    always_ff @(posedge clock) begin
        if (reset && ram_we_s) begin
            if (ram_be_s[0]) begin
                ram_q[idx_q][7:0] <= ram_wd_s[7:0];
            end
            if (ram_be_s[1]) begin
                ram_q[idx_q][15:8] <= ram_wd_s[15:8];
            end
        end
    end

    // Instruction fetch: reads the pre-edge RAM word, so same-edge writes are not seen
    always_comb begin
        inst_in_range_s = ({1'b0, inst_addr[ADDR_W-1:1]} < RAM_LIMIT);
        if (inst_req) begin
            inst_done_d = 1'b1;
            if (inst_in_range_s) begin
                inst_out_d = ram_q[inst_addr[RAM_AW:1]];
            end else begin
                inst_out_d = 16'h0000;
            end
        end else begin
            inst_done_d = 1'b0;
            inst_out_d  = inst_out_q;
        end
    end

    // Instruction port registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            inst_out_q  <= 16'h0000;
            inst_done_q <= 1'b0;
        end else begin
            inst_out_q  <= inst_out_d;
            inst_done_q <= inst_done_d;
        end
    end

    assign data_rdata = data_rdata_q;
    assign data_done  = data_done_q;
    assign data_err   = data_err_q;
    assign mmio_req   = mmio_req_q;
    assign mmio_sel   = mmio_sel_q;
    assign mmio_write = mmio_write_q;
    assign mmio_wdata = mmio_wdata_q;
    assign inst_out   = inst_out_q;
    assign inst_done  = inst_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven data-port vectors with a response scoreboard,
// plus hand sequences for MMIO wait/timeout, back-to-back requests,
// instruction read-before-write and reset during a RAM write.
module tb_mem_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] data_addr;
    logic [15:0] data_wdata;
    logic        data_size;
    logic        data_write;
    logic        data_req;
    logic [15:0] data_rdata;
    logic        data_done;
    logic        data_err;
    logic [15:0] inst_addr;
    logic        inst_req;
    logic [15:0] inst_out;
    logic        inst_done;
    logic        mmio_req;
    logic [3:0]  mmio_sel;
    logic        mmio_write;
    logic [7:0]  mmio_wdata;
    logic [3:0]  mmio_done;
    logic [31:0] mmio_rdata;

    always #5 clock = ~clock;

    mem_ctrl #(
        .ADDR_W(16), .RAM_WORDS(2048), .MMIO_BASE(16'hF000),
        .N_MMIO(4), .MMIO_TIMEOUT(255)
    ) dut (
        .clock(clock), .reset(reset),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_size(data_size),
        .data_write(data_write), .data_req(data_req), .data_rdata(data_rdata),
        .data_done(data_done), .data_err(data_err),
        .inst_addr(inst_addr), .inst_req(inst_req), .inst_out(inst_out),
        .inst_done(inst_done),
        .mmio_req(mmio_req), .mmio_sel(mmio_sel), .mmio_write(mmio_write),
        .mmio_wdata(mmio_wdata), .mmio_done(mmio_done), .mmio_rdata(mmio_rdata)
    );

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
        logic        chk_rd;
    } exp_t;

    typedef struct {
        string       nm;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        size;
        logic        write;
        logic [15:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input string nm, input logic [15:0] a, input logic [15:0] wd,
                           input logic sz, input logic wr, input logic [15:0] er,
                           input logic ee, input int el);
        vec_t v;
        v.nm = nm; v.addr = a; v.wdata = wd; v.size = sz; v.write = wr;
        v.rdata = er; v.err = ee; v.lat = el;
        vecs.push_back(v);
    endtask

    // Drive a request and push its expected response
    task automatic start_req(input logic [15:0] a, input logic [15:0] wd, input logic sz,
                             input logic wr, input logic [15:0] er, input logic ee,
                             input int el, input logic ck);
        exp_t e;
        data_addr = a; data_wdata = wd; data_size = sz; data_write = wr; data_req = 1'b1;
        e.rdata = er; e.err = ee; e.lat = el; e.chk_rd = ck;
        sb_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare against the response now on the port
    task automatic check_resp(input string nm, input int cyc);
        exp_t e;
        if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: unexpected data_done at cycle %0d", nm, cyc);
        end else begin
            e = sb_q.pop_front();
            check({nm, " latency"}, cyc, e.lat);
            check({nm, " err"}, data_err, e.err);
            if (e.chk_rd) begin
                check({nm, " rdata"}, data_rdata, e.rdata);
            end
        end
    endtask

    task automatic no_resp(input string nm, input int budget);
        total++; bad++;
        $display("FAIL %s: no data_done within %0d cycles", nm, budget);
        if (sb_q.size() > 0) begin
            void'(sb_q.pop_front());
        end
    endtask

    // One complete data access, starting and ending on a falling edge
    task automatic do_access(input string nm, input logic [15:0] a, input logic [15:0] wd,
                             input logic sz, input logic wr, input logic [15:0] er,
                             input logic ee, input int el);
        bit got = 1'b0;
        start_req(a, wd, sz, wr, er, ee, el, (!wr) || ee);
        for (int c = 1; c <= 400 && !got; c++) begin
            @(negedge clock);
            if (data_done) begin
                got = 1'b1;
                check_resp(nm, c);
            end
        end
        data_req = 1'b0;
        if (!got) begin
            no_resp(nm, 400);
        end else begin
            @(negedge clock);
            check({nm, " one-cycle done"}, data_done, 1'b0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int hold_bad;
        int n_done;

        // Vector table: RAM byte/halfword paths, alignment and decode boundaries
        add_vec("hw_wr_0000",   16'h0000, 16'h0BAD, 1'b1, 1'b1, 16'h0000, 1'b0, 2);
        add_vec("hw_wr_0100",   16'h0100, 16'h1122, 1'b1, 1'b1, 16'h0000, 1'b0, 2);
        add_vec("b_wr_0101",    16'h0101, 16'h77A5, 1'b0, 1'b1, 16'h0000, 1'b0, 2);
        add_vec("hw_rd_0100",   16'h0100, 16'h0000, 1'b1, 1'b0, 16'hA522, 1'b0, 2);
        add_vec("b_rd_0100",    16'h0100, 16'h0000, 1'b0, 1'b0, 16'h0022, 1'b0, 2);
        add_vec("b_rd_0101",    16'h0101, 16'h0000, 1'b0, 1'b0, 16'h00A5, 1'b0, 2);
        add_vec("hw_wr_0002",   16'h0002, 16'hCAFE, 1'b1, 1'b1, 16'h0000, 1'b0, 2);
        add_vec("hw_rd_0003",   16'h0003, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1);
        add_vec("hw_wr_0003",   16'h0003, 16'hDEAD, 1'b1, 1'b1, 16'h0000, 1'b1, 1);
        add_vec("hw_rd_0002",   16'h0002, 16'h0000, 1'b1, 1'b0, 16'hCAFE, 1'b0, 2);
        add_vec("b_wr_0fff",    16'h0FFF, 16'h005A, 1'b0, 1'b1, 16'h0000, 1'b0, 2);
        add_vec("b_rd_0fff",    16'h0FFF, 16'h0000, 1'b0, 1'b0, 16'h005A, 1'b0, 2);
        add_vec("b_rd_1000",    16'h1000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1);
        add_vec("b_wr_1000",    16'h1000, 16'h00EE, 1'b0, 1'b1, 16'h0000, 1'b1, 1);
        add_vec("hw_rd_0000",   16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0BAD, 1'b0, 2);
        add_vec("hw_rd_f000",   16'hF000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1);
        add_vec("b_rd_f004",    16'hF004, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1);
        add_vec("b_rd_efff",    16'hEFFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1);
        add_vec("b_wr_0100",    16'h0100, 16'hFF3C, 1'b0, 1'b1, 16'h0000, 1'b0, 2);
        add_vec("hw_rd_0100_b", 16'h0100, 16'h0000, 1'b1, 1'b0, 16'hA53C, 1'b0, 2);

        // Reset with requests asserted: everything must stay quiet
        reset = 1'b0; data_addr = 16'h0000; data_wdata = 16'h0000; data_size = 1'b0;
        data_write = 1'b0; data_req = 1'b1; inst_addr = 16'h0000; inst_req = 1'b1;
        mmio_done = 4'b0000; mmio_rdata = 32'h0000_0000;
        repeat (3) @(negedge clock);
        check("rst data_done", data_done, 1'b0);
        check("rst data_err", data_err, 1'b0);
        check("rst data_rdata", data_rdata, 16'h0000);
        check("rst inst_done", inst_done, 1'b0);
        check("rst inst_out", inst_out, 16'h0000);
        check("rst mmio_req", mmio_req, 1'b0);
        check("rst mmio_sel", mmio_sel, 4'b0000);
        check("rst mmio_write", mmio_write, 1'b0);
        data_req = 1'b0; inst_req = 1'b0; reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            do_access(vecs[i].nm, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].write,
                      vecs[i].rdata, vecs[i].err, vecs[i].lat);
        end

        // Request held through RESP: second acceptance only after the done cycle
        start_req(16'h0100, 16'h0000, 1'b1, 1'b0, 16'hA53C, 1'b0, 2, 1'b1);
        sb_q.push_back('{16'hA53C, 1'b0, 5, 1'b1});
        n_done = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clock);
            if (data_done) begin
                n_done++;
                check_resp("b2b", c);
            end
            if (c == 5) data_req = 1'b0;
        end
        check("b2b done count", n_done, 2);

        // MMIO read of channel 2, completion 5 cycles in, noise on other channels
        mmio_rdata = 32'hDD11_BBAA;
        start_req(16'hF002, 16'h0000, 1'b0, 1'b0, 16'h003C, 1'b0, 6, 1'b1);
        got = 1'b0; hold_bad = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            @(negedge clock);
            if (data_done) begin
                got = 1'b1;
                check_resp("mmio_rd", c);
                check("mmio_rd req dropped", mmio_req, 1'b0);
            end else begin
                if (!(mmio_req === 1'b1 && mmio_sel === 4'b0100 && mmio_write === 1'b0)) hold_bad++;
                if (c == 2) begin
                    mmio_done = 4'b1011;
                end else if (c == 5) begin
                    mmio_done = 4'b0100;
                    mmio_rdata = 32'hDD3C_BBAA;
                end else begin
                    mmio_done = 4'b0000;
                end
            end
        end
        data_req = 1'b0; mmio_done = 4'b0000; mmio_rdata = 32'hDD77_BBAA;
        if (!got) no_resp("mmio_rd", 20);
        check("mmio_rd held outputs", hold_bad, 0);
        @(negedge clock);

        // MMIO write to channel 1 that never completes: timeout error
        mmio_done = 4'b1101;
        start_req(16'hF001, 16'h00C7, 1'b0, 1'b1, 16'h0000, 1'b1, 256, 1'b1);
        got = 1'b0; hold_bad = 0;
        for (int c = 1; c <= 300 && !got; c++) begin
            @(negedge clock);
            if (data_done) begin
                got = 1'b1;
                check_resp("mmio_tmo", c);
                check("mmio_tmo req dropped", mmio_req, 1'b0);
            end else if (!(mmio_req === 1'b1 && mmio_sel === 4'b0010 &&
                           mmio_write === 1'b1 && mmio_wdata === 8'hC7)) begin
                hold_bad++;
            end
        end
        data_req = 1'b0; mmio_done = 4'b0000;
        if (!got) no_resp("mmio_tmo", 300);
        check("mmio_tmo held outputs", hold_bad, 0);
        @(negedge clock);

        // Instruction fetch on the same edge as a halfword write to word 0x10
        do_access("hw_wr_0020", 16'h0020, 16'hBEEF, 1'b1, 1'b1, 16'h0000, 1'b0, 2);
        start_req(16'h0020, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b0, 2, 1'b0);
        @(negedge clock);
        inst_addr = 16'h0021; inst_req = 1'b1;
        @(negedge clock);
        check("rbw data_done", data_done, 1'b1);
        if (data_done) check_resp("rbw_wr", 2);
        check("rbw inst_done", inst_done, 1'b1);
        check("rbw inst_out old", inst_out, 16'hBEEF);
        data_req = 1'b0;
        @(negedge clock);
        check("rbw inst_out new", inst_out, 16'h1234);
        inst_addr = 16'h1000;
        @(negedge clock);
        check("inst oor done", inst_done, 1'b1);
        check("inst oor out", inst_out, 16'h0000);
        inst_addr = 16'h0100;
        @(negedge clock);
        check("inst 0100 out", inst_out, 16'hA53C);
        inst_req = 1'b0; inst_addr = 16'h0002;
        @(negedge clock);
        check("inst idle done", inst_done, 1'b0);
        check("inst idle hold", inst_out, 16'hA53C);

        // Reset asserted while a halfword write sits in RAM_WR
        do_access("hw_wr_0040", 16'h0040, 16'h7777, 1'b1, 1'b1, 16'h0000, 1'b0, 2);
        data_addr = 16'h0040; data_wdata = 16'h5555; data_size = 1'b1;
        data_write = 1'b1; data_req = 1'b1;
        @(negedge clock);
        reset = 1'b0; inst_req = 1'b1; inst_addr = 16'h0040;
        @(negedge clock);
        check("rwr data_done", data_done, 1'b0);
        check("rwr data_err", data_err, 1'b0);
        check("rwr data_rdata", data_rdata, 16'h0000);
        check("rwr inst_done", inst_done, 1'b0);
        check("rwr inst_out", inst_out, 16'h0000);
        check("rwr mmio_req", mmio_req, 1'b0);
        check("rwr mmio_sel", mmio_sel, 4'b0000);
        check("rwr mmio_write", mmio_write, 1'b0);
        @(negedge clock);
        check("rwr held data_done", data_done, 1'b0);
        check("rwr held inst_done", inst_done, 1'b0);
        reset = 1'b1; data_req = 1'b0; inst_req = 1'b0;
        @(negedge clock);
        do_access("hw_rd_0040", 16'h0040, 16'h0000, 1'b1, 1'b0, 16'h7777, 1'b0, 2);

        check("scoreboard drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: data/instruction byte-address width.
REQ-002 SHALL have parameter RAM_WORDS, default 2048: internal 16-bit RAM depth in words.
REQ-003 SHALL have parameter MMIO_BASE, default 16'hF000: first MMIO byte address; addresses below it are RAM space.
REQ-004 SHALL have parameter N_MMIO, default 4: MMIO channel count; channel k is at MMIO_BASE+k.
REQ-005 SHALL have parameter MMIO_TIMEOUT, default 255: maximum MMIO wait cycles before an error response.
REQ-006 SHALL have port clock, in, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, in, 1: reset is synchronous and active-low.
REQ-008 SHALL have port data_addr, in, ADDR_W: data byte address.
REQ-009 SHALL have port data_wdata, in, 16: write data; byte accesses use [7:0].
REQ-010 SHALL have port data_size, in, 1: 0 = byte, 1 = halfword.
REQ-011 SHALL have port data_write, in, 1: 1 = write, 0 = read.
REQ-012 SHALL have port data_req, in, 1: request; held by the requester until data_done.
REQ-013 SHALL have port data_rdata, out, 16: read data; valid only while data_done=1.
REQ-014 SHALL have port data_done, out, 1: one-cycle completion pulse.
REQ-015 SHALL have port data_err, out, 1: error flag; valid only while data_done=1.
REQ-016 SHALL have port inst_addr, in, ADDR_W: instruction byte address; bit 0 ignored.
REQ-017 SHALL have port inst_req, in, 1: instruction fetch request.
REQ-018 SHALL have port inst_out, out, 16: fetched word.
REQ-019 SHALL have port inst_done, out, 1: fetch completion pulse.
REQ-020 SHALL have port mmio_req, out, 1: MMIO access in progress.
REQ-021 SHALL have port mmio_sel, out, N_MMIO: one-hot selected channel.
REQ-022 SHALL have port mmio_write, out, 1: MMIO write qualifier.
REQ-023 SHALL have port mmio_wdata, out, 8: MMIO write byte.
REQ-024 SHALL have port mmio_done, in, N_MMIO: per-channel completion.
REQ-025 SHALL have port mmio_rdata, in, 8*N_MMIO: per-channel read byte; channel k is in bits [8k+7:8k].

Function
REQ-026 SHALL implement the data FSM with states IDLE, RAM_RD, RAM_WR, MMIO_WAIT and RESP.
REQ-027 SHALL accept a request only in IDLE with data_req=1, latching address, data, size and write at that point; the acceptance edge is cycle 0.
REQ-028 SHALL decode addresses as RAM when addr<MMIO_BASE and addr[ADDR_W-1:1]<RAM_WORDS.
REQ-029 SHALL decode addresses as MMIO channel k when addr==MMIO_BASE+k and k<N_MMIO.
REQ-030 SHALL treat every other address as unmapped.
REQ-031 SHALL give a RAM read IDLE->RAM_RD->RESP, with data_done=1 on cycle 2.
REQ-032 SHALL return RAM read data as: byte read = {8'h00, selected byte}, where addr[0]=0 selects the low byte; halfword read = the full word.
REQ-033 SHALL give a RAM write IDLE->RAM_WR->RESP, with data_done on cycle 2.
REQ-034 SHALL perform RAM writes with byte enables (no read-modify-write): a byte write changes only the addressed byte; a halfword write changes both bytes.
REQ-035 SHALL respond with data_err=1, data_rdata=0 and data_done on cycle 1, with no RAM/MMIO side effect, to: halfword access with addr[0]=1; halfword access to MMIO; unmapped address.
REQ-036 SHALL, for MMIO, enter MMIO_WAIT and hold mmio_req=1, mmio_sel=one-hot(k), mmio_write and mmio_wdata=wdata[7:0] stable until mmio_done[k]=1.
REQ-037 SHALL then drop mmio_req on the next edge and go to RESP with data_rdata={8'h00, channel k byte captured at the mmio_done cycle}.
REQ-038 SHALL ignore mmio_done bits of unselected channels.
REQ-039 SHALL abort MMIO_WAIT after MMIO_TIMEOUT cycles without mmio_done[k]: drop mmio_req and go to RESP with data_err=1, data_rdata=0.
REQ-040 SHALL keep the timeout counter 8+ bits wide, saturating, and clear it on every accept.
REQ-041 SHALL have RESP assert data_done for exactly one cycle and then return to IDLE.
REQ-042 SHALL not accept a new request in the RESP cycle; the earliest next acceptance is the cycle after data_done.
REQ-043 SHALL make the instruction port independent of the data FSM and never stall: inst_req at edge N -> inst_done=1 and inst_out=RAM[inst_addr[ADDR_W-1:1]] during cycle N+1.
REQ-044 SHALL return inst_out=16'h0000 for out-of-range instruction addresses.
REQ-045 SHALL, when an instruction fetch and a data write hit the same word on the same edge, return the old data on inst_out (read-before-write).
REQ-046 SHALL hold inst_out at its last value when inst_req=0; inst_done=0 in that case.

Reset
REQ-047 SHALL, with reset=0 at a clock edge, set FSM=IDLE and data_done, data_err, inst_done, mmio_req, mmio_write = 0, mmio_sel=0, data_rdata=0, inst_out=0, and timeout counter=0.
REQ-048 SHALL preserve RAM contents across reset, with no initialisation required.
REQ-049 SHALL abort any in-flight access on reset with no write commit and no data_done; this includes reset asserted during RAM_WR.
REQ-050 SHALL ignore data_req and inst_req while reset=0.

Verification
REQ-051 SHALL verify a byte write of 8'hA5 to 0x0101 followed by a halfword read of 0x0100 -> rdata=16'hA5xx with the low byte unchanged and done at cycle 2 of each access.
REQ-052 SHALL verify a halfword read of 0x0003 -> data_err=1, done on cycle 1, and RAM unchanged.
REQ-053 SHALL verify an MMIO read of MMIO_BASE+2 with mmio_done[2] raised 5 cycles later with byte 8'h3C -> mmio_sel=4'b0100 held, rdata=16'h003C, err=0.
REQ-054 SHALL verify an MMIO write to MMIO_BASE+1 with mmio_done never asserted -> mmio_req low and data_err=1 after 255 wait cycles.
REQ-055 SHALL verify a same-edge inst fetch and halfword write of 16'h1234 to word 0x10 (old value 16'hBEEF) -> inst_out=16'hBEEF, with the next fetch returning 16'h1234.
REQ-056 SHALL verify reset=0 asserted during RAM_WR of 16'h5555 to a word -> no data_done, the word keeps its old value, and all outputs are zero on the next cycle.
